// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures CPU register-file and data-memory commit events
// as ordered records and presents them to a reader through a valid/ready port.
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [31:0]              grf_pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_wd,
    input  logic                     dm_we,
    input  logic [31:0]              dm_pc,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_wd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_type,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNTW-1:0]          ovf_cnt,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic        typ;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNTW-1:0] ovf_cnt_q, ovf_cnt_d;
    logic            proto_err_q, proto_err_d;

    logic grf_evt, dm_evt, evt, deq, enq, drop;
    rec_t wr_rec;
    rec_t head;

    // Handshake: a record transfers on a rising edge where out_valid and
    // out_ready are both 1; out_valid never depends on out_ready, and the head
    // fields are held until that transfer happens.
    always_comb begin
        grf_evt = grf_we && (grf_addr != 5'd0);
        dm_evt  = dm_we;
        evt     = grf_evt || dm_evt;
        deq     = (count_q != '0) && out_ready;
        enq     = evt && ((count_q != FULL_CNT) || deq);
        drop    = evt && !enq;

        // GRF wins a same-cycle collision; the DM event is discarded.
        if (grf_evt) begin
            wr_rec = '{typ: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wd};
        end else begin
            wr_rec = '{typ: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wd};
        end

        wr_ptr_d    = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNTW'(1);
        end

        proto_err_d = proto_err_q || (grf_evt && dm_evt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_cnt_q   <= ovf_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Entry storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_type  = head.typ;
    assign out_pc    = head.pc;
    assign out_addr  = head.addr;
    assign out_data  = head.data;
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 Parameter CNTW, default 16, overflow counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 grf_we  input  1  CPU register-file write commit this cycle.
REQ-006 grf_pc  input  32  PC of the committing instruction.
REQ-007 grf_addr  input  5  destination register number.
REQ-008 grf_wd  input  32  register write data.
REQ-009 dm_we  input  1  CPU data-memory store commit this cycle.
REQ-010 dm_pc  input  32  PC of the storing instruction.
REQ-011 dm_addr  input  32  store byte address.
REQ-012 dm_wd  input  32  store data.
REQ-013 out_valid  output  1  head entry available.
REQ-014 out_ready  input  1  reader accepts the head entry.
REQ-015 out_type  output  1  0 = GRF record, 1 = DM record.
REQ-016 out_pc / out_addr / out_data  output  32 each  head record fields; GRF address zero-extended into out_addr.
REQ-017 full  output  1  FIFO holds DEPTH entries.
REQ-018 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-019 ovf_cnt  output  CNTW  number of dropped events.
REQ-020 proto_err  output  1  sticky; simultaneous grf_we and dm_we seen.

Function
REQ-021 Event qualification: GRF event = grf_we=1 and grf_addr!=0; DM event = dm_we=1; GRF writes to register 0 are discarded silently and do not count as drops.
REQ-022 At most one record is enqueued per cycle; GRF and DM events in the same cycle -> GRF record enqueued, DM event discarded, proto_err set to 1 (ovf_cnt unchanged).
REQ-023 Enqueue occurs on the rising edge when a qualified event is present and (count<DEPTH or a dequeue occurs in the same cycle).
REQ-024 Dequeue occurs on the rising edge when out_valid=1 and out_ready=1.
REQ-025 Storage is circular with read/write pointers wrapping from DEPTH-1 to 0; records exit in commit order.
REQ-026 Latency: a record enqueued at edge N is visible at the outputs after edge N (out_valid=1 in cycle N+1); no combinational path from event inputs to out_*.
REQ-027 out_* fields hold stable while out_valid=1 and out_ready=0; fields are don't-care when out_valid=0.
REQ-028 Simultaneous enqueue and dequeue: count unchanged, legal at any occupancy including full and DEPTH-1.
REQ-029 Dequeue with out_valid=0 is ignored; count never underflows.
REQ-030 Overflow: qualified event while full and no same-cycle dequeue -> record dropped, FIFO contents unchanged, ovf_cnt increments, saturating at all-ones.
REQ-031 full = (count==DEPTH); out_valid = (count!=0); both derived from registered state.
REQ-032 Input fields are sampled only on the enqueue edge; changes on other cycles have no effect.

Reset
REQ-033 reset=0 immediately, without a clock edge, forces: count=0, out_valid=0, full=0, pointers=0, ovf_cnt=0, proto_err=0.
REQ-034 Reset asserted mid-operation discards all stored records; entry storage contents need not be cleared.
REQ-035 First enqueue is possible on the first rising edge after reset returns to 1.

Verification
REQ-036 Single GRF write: grf_we=1, pc=0x3000, addr=5, wd=0x12345678, out_ready=0 -> next cycle out_valid=1, type=0, pc=0x3000, addr=0x5, data=0x12345678, count=1.
REQ-037 $0 filter: grf_we=1, grf_addr=0 for 3 cycles -> count stays 0, ovf_cnt=0.
REQ-038 Fill/overflow: 10 DM events, pc=0x3000+4i, out_ready=0, DEPTH=8 -> full=1, count=8, ovf_cnt=2; then drain with out_ready=1 -> pcs 0x3000..0x301C in order, then out_valid=0.
REQ-039 Full with simultaneous enq/deq: full, out_ready=1 plus new event -> count stays 8, head advances, new record last out.
REQ-040 Collision: grf_we=1 (addr 3) and dm_we=1 same cycle -> one GRF record enqueued, proto_err=1 until reset.
REQ-041 Async reset: 4 entries stored, reset=0 between clock edges -> out_valid=0, count=0, ovf_cnt=0 before the next edge.
